// File: rtl/rh_cs1_mdrv_if.sv
// rh_cs1_mdrv_if
// Bundle of the signals between the UBA device interface, the RH11 controller
// core, the per-drive register files and the CS1 register block.
//   master : the side that drives strobes, data, controller state and drive status
//   slave  : the CS1 block, which returns the CS1 image and the interrupt level
// Device data is big-endian [0:35]. The CS1 image occupies the last 16 bits,
// so little-endian CS1 bit k sits at devDATAI[35-k].
interface rh_cs1_mdrv_if #(
    parameter int NDRV = 8,
    parameter int UW   = 3,
    parameter int NERR = 8
);
    logic              devRESET;
    logic              devLOBYTE;
    logic              devHIBYTE;
    logic [0:35]       devDATAI;
    logic              rhcs1WRITE;
    logic              rhCLR;
    logic              rhCLRGO;
    logic              rhCLRTRE;
    logic [NERR-1:0]   rhERR;
    logic [UW-1:0]     rhUNIT;
    logic [1:0]        rhBA;
    logic              rhIACK;
    logic [NDRV-1:0]   drvATA;
    logic [NDRV-1:0]   drvERR;
    logic [NDRV-1:0]   drvDVA;
    logic [NDRV-1:0]   drvGO;
    logic [5*NDRV-1:0] drvFUN;
    logic [15:0]       rhCS1;
    logic              rhINTR;

    modport master (
        output devRESET, devLOBYTE, devHIBYTE, devDATAI, rhcs1WRITE,
        output rhCLR, rhCLRGO, rhCLRTRE, rhERR, rhUNIT, rhBA, rhIACK,
        output drvATA, drvERR, drvDVA, drvGO, drvFUN,
        input  rhCS1, rhINTR
    );

    modport slave (
        input  devRESET, devLOBYTE, devHIBYTE, devDATAI, rhcs1WRITE,
        input  rhCLR, rhCLRGO, rhCLRTRE, rhERR, rhUNIT, rhBA, rhIACK,
        input  drvATA, drvERR, drvDVA, drvGO, drvFUN,
        output rhCS1, rhINTR
    );
endinterface

// File: rtl/rh_cs1_mdrv.sv
// rh_cs1_mdrv
// RH11 Control/Status Register 1 for a Massbus controller with NDRV drives.
// Assembles the CS1 readback image from the selected unit's drive status and
// the controller error sources, holds the writable TRE/PSEL/IE bits, and runs
// the interrupt request handshake (RDY-edge, SC-edge and IE-write triggers).
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : rh_cs1_mdrv_if slave modport (device strobes/data, controller
//          clears and errors, unit select, per-drive status; CS1 and INTR out)
module rh_cs1_mdrv #(
    parameter int NDRV    = 8,
    parameter int UW      = 3,
    parameter int NERR    = 8,
    parameter int IACKCLR = 1
) (
    input  logic             clk,
    input  logic             rst,
    rh_cs1_mdrv_if.slave     bus
);
    localparam logic IACK_CLR = (IACKCLR != 0);

    typedef enum logic {IDLE, PEND} state_t;

    state_t state_q, state_d;
    logic   tre_q, tre_d;
    logic   last_tre_q, last_tre_d;
    logic   psel_q, psel_d;
    logic   ie_q, ie_d;
    logic   last_rdy_q, last_rdy_d;
    logic   last_sc_q, last_sc_d;

    logic [UW-1:0]   unit;
    logic [NERR-1:0] err_lvl;
    logic [4:0]      fun_arr [NDRV];
    logic [4:0]      s_fun;
    logic            s_go, s_err, s_dva;
    logic            ata, rdy, sc, stat_tre;
    logic            clr_ctl, wr_lo, wr_hi;
    logic            d_bit0, d_bit6, d_bit10;
    logic            trig;
    logic            unused_data;

    assign unit    = bus.rhUNIT;
    assign err_lvl = bus.rhERR;

    // Split the packed per-drive function bus into one 5-bit field per drive
    for (genvar n = 0; n < NDRV; n++) begin : g_fun
        assign fun_arr[n] = bus.drvFUN[5*n +: 5];
    end

    assign s_fun = fun_arr[unit];
    assign s_go  = bus.drvGO[unit];
    assign s_err = bus.drvERR[unit];
    assign s_dva = bus.drvDVA[unit];

    assign ata      = |bus.drvATA;
    assign rdy      = ~s_go;
    assign sc       = tre_q | ata;
    assign stat_tre = (|err_lvl) | s_err;

    // CS1 little-endian bit k lives at devDATAI[35-k]
    assign d_bit0  = bus.devDATAI[35];
    assign d_bit6  = bus.devDATAI[29];
    assign d_bit10 = bus.devDATAI[25];
    assign unused_data = ^{bus.devDATAI[0:24], bus.devDATAI[26:28], bus.devDATAI[30:34]};

    assign clr_ctl = bus.devRESET | bus.rhCLR;
    assign wr_lo   = bus.rhcs1WRITE & bus.devLOBYTE;
    assign wr_hi   = bus.rhcs1WRITE & bus.devHIBYTE;

    // Interrupt triggers; the write trigger needs no prior IE and fires only
    // for an IE=1, GO=0 write while the selected drive is ready
    assign trig = (ie_q & rdy & ~last_rdy_q)
                | (ie_q & sc & ~last_sc_q)
                | (wr_lo & d_bit6 & ~d_bit0 & rdy);

    // Next-state for the writable bits, edge detectors and interrupt FSM;
    // in every register a clear source outranks a load or set
    always_comb begin
        state_d    = state_q;
        tre_d      = tre_q;
        psel_d     = psel_q;
        ie_d       = ie_q;
        last_tre_d = stat_tre;
        last_rdy_d = rdy;
        last_sc_d  = sc;

        if (clr_ctl | bus.rhCLRTRE | bus.rhCLRGO) begin
            tre_d = 1'b0;
        end else if (stat_tre & ~last_tre_q) begin
            tre_d = 1'b1;
        end

        if (clr_ctl) begin
            psel_d = 1'b0;
        end else if (wr_hi & rdy) begin
            psel_d = d_bit10;
        end

        if (clr_ctl | (IACK_CLR & bus.rhIACK)) begin
            ie_d = 1'b0;
        end else if (wr_lo) begin
            ie_d = d_bit6;
        end

        // A trigger coinciding with an acknowledge keeps the request pending
        case (state_q)
            IDLE: if (trig) state_d = PEND;
            PEND: if (bus.rhIACK & ~trig) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr_ctl) begin
            state_d = IDLE;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tre_q      <= 1'b0;
            last_tre_q <= 1'b0;
            psel_q     <= 1'b0;
            ie_q       <= 1'b0;
            last_rdy_q <= 1'b0;
            last_sc_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tre_q      <= tre_d;
            last_tre_q <= last_tre_d;
            psel_q     <= psel_d;
            ie_q       <= ie_d;
            last_rdy_q <= last_rdy_d;
            last_sc_q  <= last_sc_d;
        end
    end

    // CS1: SC TRE CPE 0 DVA PSEL BA[17:16] RDY IE FUN[5:1] GO
    assign bus.rhCS1  = {sc, tre_q, 1'b0, 1'b0, s_dva, psel_q, bus.rhBA,
                         rdy, ie_q, s_fun, s_go};
    assign bus.rhINTR = (state_q == PEND);
endmodule

// File: tb/tb_rh_cs1_mdrv.sv
// tb_rh_cs1_mdrv
// Self-checking bench for rh_cs1_mdrv: directed scenarios for reset, IE write,
// unit/function readback, TRE, PSEL, ATA/SC edges, unit switching and async
// reset, then a randomized run against a rule-level reference model.
module tb_rh_cs1_mdrv;
    localparam int NDRV = 8;
    localparam int UW   = 3;
    localparam int NERR = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp;
    int   n_bad;

    always #5 clk = ~clk;

    rh_cs1_mdrv_if #(.NDRV(NDRV), .UW(UW), .NERR(NERR)) bus ();

    rh_cs1_mdrv #(.NDRV(NDRV), .UW(UW), .NERR(NERR), .IACKCLR(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.devRESET   = 1'b0;
        bus.devLOBYTE  = 1'b0;
        bus.devHIBYTE  = 1'b0;
        bus.devDATAI   = '0;
        bus.rhcs1WRITE = 1'b0;
        bus.rhCLR      = 1'b0;
        bus.rhCLRGO    = 1'b0;
        bus.rhCLRTRE   = 1'b0;
        bus.rhERR      = '0;
        bus.rhUNIT     = '0;
        bus.rhBA       = '0;
        bus.rhIACK     = 1'b0;
        bus.drvATA     = '0;
        bus.drvERR     = '0;
        bus.drvDVA     = '0;
        bus.drvGO      = '0;
        bus.drvFUN     = '0;
    endtask

    // One-clock CS1 write strobe
    task automatic wr16(input logic lo, input logic hi, input logic [15:0] d);
        bus.rhcs1WRITE = 1'b1;
        bus.devLOBYTE  = lo;
        bus.devHIBYTE  = hi;
        bus.devDATAI   = {20'h0, d};
        cyc();
        bus.rhcs1WRITE = 1'b0;
        bus.devLOBYTE  = 1'b0;
        bus.devHIBYTE  = 1'b0;
        bus.devDATAI   = '0;
    endtask

    task automatic pulse_iack();
        bus.rhIACK = 1'b1;
        cyc();
        bus.rhIACK = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        n_cmp++;
        if (bus.rhCS1 !== 16'h0080) begin
            n_bad++; $display("[TB] FAIL reset_cs1: got %h want 0080", bus.rhCS1);
        end
        n_cmp++;
        if (bus.rhINTR !== 1'b0) begin
            n_bad++; $display("[TB] FAIL reset_intr: got %b want 0", bus.rhINTR);
        end
        rst = 1'b0;
        cyc();
        n_cmp++;
        if (bus.rhCS1 !== 16'h0080 || bus.rhINTR !== 1'b0) begin
            n_bad++; $display("[TB] FAIL post_reset: got cs1=%h intr=%b want 0080/0", bus.rhCS1, bus.rhINTR);
        end
    endtask

    task automatic test_ie_write();
        wr16(1'b1, 1'b0, 16'h0040);
        n_cmp++;
        if (bus.rhCS1 !== 16'h00C0 || bus.rhINTR !== 1'b1) begin
            n_bad++; $display("[TB] FAIL ie_write: got cs1=%h intr=%b want 00c0/1", bus.rhCS1, bus.rhINTR);
        end
        pulse_iack();
        n_cmp++;
        if (bus.rhCS1 !== 16'h0080 || bus.rhINTR !== 1'b0) begin
            n_bad++; $display("[TB] FAIL ie_iack: got cs1=%h intr=%b want 0080/0", bus.rhCS1, bus.rhINTR);
        end
    endtask

    task automatic test_unit_fun();
        bus.rhUNIT = 3'd3;
        bus.drvGO  = 8'h08;
        bus.drvFUN = 40'h19 << 15;
        #1;
        n_cmp++;
        if (bus.rhCS1 !== 16'h0033) begin
            n_bad++; $display("[TB] FAIL unit_fun: got %h want 0033", bus.rhCS1);
        end
        cyc();
        wr16(1'b1, 1'b0, 16'h0040);
        n_cmp++;
        if (bus.rhCS1 !== 16'h0073 || bus.rhINTR !== 1'b0) begin
            n_bad++; $display("[TB] FAIL ie_busy: got cs1=%h intr=%b want 0073/0", bus.rhCS1, bus.rhINTR);
        end
        bus.drvGO = 8'h00;
        #1;
        n_cmp++;
        if (bus.rhCS1 !== 16'h00F2 || bus.rhINTR !== 1'b0) begin
            n_bad++; $display("[TB] FAIL go_drop: got cs1=%h intr=%b want 00f2/0", bus.rhCS1, bus.rhINTR);
        end
        cyc();
        n_cmp++;
        if (bus.rhINTR !== 1'b1) begin
            n_bad++; $display("[TB] FAIL rdy_edge_intr: got %b want 1", bus.rhINTR);
        end
        pulse_iack();
        bus.rhUNIT = '0;
        bus.drvFUN = '0;
        n_cmp++;
        if (bus.rhINTR !== 1'b0) begin
            n_bad++; $display("[TB] FAIL rdy_edge_iack: got %b want 0", bus.rhINTR);
        end
        cyc();
    endtask

    task automatic test_tre();
        bus.rhERR = 8'h10;
        #1;
        n_cmp++;
        if (bus.rhCS1 !== 16'h0080) begin
            n_bad++; $display("[TB] FAIL tre_prelatch: got %h want 0080", bus.rhCS1);
        end
        cyc();
        n_cmp++;
        if (bus.rhCS1 !== 16'hC080) begin
            n_bad++; $display("[TB] FAIL tre_set: got %h want c080", bus.rhCS1);
        end
        bus.rhCLRTRE = 1'b1;
        cyc();
        bus.rhCLRTRE = 1'b0;
        cyc();
        n_cmp++;
        if (bus.rhCS1 !== 16'h0080) begin
            n_bad++; $display("[TB] FAIL tre_clr_hold: got %h want 0080", bus.rhCS1);
        end
        bus.rhERR = '0;
        cyc();
        bus.rhERR = 8'h10;
        cyc();
        n_cmp++;
        if (bus.rhCS1 !== 16'hC080 || bus.rhINTR !== 1'b0) begin
            n_bad++; $display("[TB] FAIL tre_reset_again: got cs1=%h intr=%b want c080/0", bus.rhCS1, bus.rhINTR);
        end
        bus.rhERR    = '0;
        bus.rhCLRTRE = 1'b1;
        cyc();
        bus.rhCLRTRE = 1'b0;
        cyc();
        bus.rhERR   = 8'h10;
        bus.rhCLRGO = 1'b1;
        cyc();
        bus.rhCLRGO = 1'b0;
        n_cmp++;
        if (bus.rhCS1 !== 16'h0080) begin
            n_bad++; $display("[TB] FAIL tre_clear_beats_set: got %h want 0080", bus.rhCS1);
        end
        bus.rhERR = '0;
        cyc();
    endtask

    task automatic test_psel();
        bus.drvGO = 8'h01;
        cyc();
        wr16(1'b0, 1'b1, 16'h0400);
        bus.drvGO = 8'h00;
        #1;
        n_cmp++;
        if (bus.rhCS1 !== 16'h0080) begin
            n_bad++; $display("[TB] FAIL psel_busy: got %h want 0080", bus.rhCS1);
        end
        cyc();
        wr16(1'b0, 1'b1, 16'h0400);
        n_cmp++;
        if (bus.rhCS1 !== 16'h0480) begin
            n_bad++; $display("[TB] FAIL psel_load: got %h want 0480", bus.rhCS1);
        end
        wr16(1'b1, 1'b0, 16'h0040);
        n_cmp++;
        if (bus.rhCS1 !== 16'h04C0 || bus.rhINTR !== 1'b1) begin
            n_bad++; $display("[TB] FAIL psel_ie: got cs1=%h intr=%b want 04c0/1", bus.rhCS1, bus.rhINTR);
        end
        bus.rhCLR = 1'b1;
        cyc();
        bus.rhCLR = 1'b0;
        n_cmp++;
        if (bus.rhCS1 !== 16'h0080 || bus.rhINTR !== 1'b0) begin
            n_bad++; $display("[TB] FAIL rhclr: got cs1=%h intr=%b want 0080/0", bus.rhCS1, bus.rhINTR);
        end
    endtask

    task automatic test_ata_back_to_back();
        // bit0 set: IE loads but the write itself raises no interrupt
        wr16(1'b1, 1'b0, 16'h0041);
        n_cmp++;
        if (bus.rhCS1 !== 16'h00C0 || bus.rhINTR !== 1'b0) begin
            n_bad++; $display("[TB] FAIL ie_go_write: got cs1=%h intr=%b want 00c0/0", bus.rhCS1, bus.rhINTR);
        end
        bus.drvATA = 8'h40;
        #1;
        n_cmp++;
        if (bus.rhCS1 !== 16'h80C0) begin
            n_bad++; $display("[TB] FAIL ata_sc: got %h want 80c0", bus.rhCS1);
        end
        cyc();
        n_cmp++;
        if (bus.rhINTR !== 1'b1) begin
            n_bad++; $display("[TB] FAIL sc_edge_intr: got %b want 1", bus.rhINTR);
        end
        bus.drvGO = 8'h01;
        cyc();
        bus.drvGO  = 8'h00;
        bus.rhIACK = 1'b1;
        cyc();
        bus.rhIACK = 1'b0;
        n_cmp++;
        if (bus.rhINTR !== 1'b1 || bus.rhCS1 !== 16'h8080) begin
            n_bad++; $display("[TB] FAIL iack_rearm: got cs1=%h intr=%b want 8080/1", bus.rhCS1, bus.rhINTR);
        end
        pulse_iack();
        n_cmp++;
        if (bus.rhINTR !== 1'b0) begin
            n_bad++; $display("[TB] FAIL iack_final: got %b want 0", bus.rhINTR);
        end
        bus.drvATA = '0;
        cyc();
    endtask

    task automatic test_unit_switch();
        bus.drvGO  = 8'h20;
        bus.rhUNIT = 3'd0;
        wr16(1'b1, 1'b0, 16'h0041);
        bus.rhUNIT = 3'd5;
        #1;
        n_cmp++;
        if (bus.rhCS1 !== 16'h0041) begin
            n_bad++; $display("[TB] FAIL unit5_cs1: got %h want 0041", bus.rhCS1);
        end
        cyc();
        bus.rhUNIT = 3'd0;
        cyc();
        n_cmp++;
        if (bus.rhINTR !== 1'b1) begin
            n_bad++; $display("[TB] FAIL unit_switch_intr: got %b want 1", bus.rhINTR);
        end
        pulse_iack();
        bus.drvGO = '0;
        cyc();
    endtask

    task automatic test_async_rst();
        wr16(1'b1, 1'b1, 16'h0440);
        bus.rhERR = 8'h01;
        cyc();
        bus.rhERR = '0;
        n_cmp++;
        if (bus.rhCS1 !== 16'hC4C0 || bus.rhINTR !== 1'b1) begin
            n_bad++; $display("[TB] FAIL pre_rst: got cs1=%h intr=%b want c4c0/1", bus.rhCS1, bus.rhINTR);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.rhCS1 !== 16'h0080 || bus.rhINTR !== 1'b0) begin
            n_bad++; $display("[TB] FAIL async_rst: got cs1=%h intr=%b want 0080/0", bus.rhCS1, bus.rhINTR);
        end
        #3;
        rst = 1'b0;
        cyc();
    endtask

    // Randomized run against a model built directly from the register rules
    task automatic test_random();
        bit m_ie, m_psel, m_tre, m_ltre, m_lrdy, m_lsc, m_pend;
        rst = 1'b1;
        idle_inputs();
        cyc();
        rst = 1'b0;
        m_ie = 0; m_psel = 0; m_tre = 0; m_ltre = 0; m_lrdy = 0; m_lsc = 0; m_pend = 0;
        for (int i = 0; i < 600; i++) begin
            logic [15:0] d16;
            logic [39:0] fsh;
            int  unit, exp_cs1;
            bit  go, rdy, ata, sc, stat, clr, wlo, whi, trig;
            bit  n_ie, n_psel, n_tre, n_pend;

            d16 = 16'($urandom);
            bus.devDATAI   = {4'($urandom), 16'($urandom), d16};
            bus.rhcs1WRITE = ($urandom_range(0, 3) == 0);
            bus.devLOBYTE  = 1'($urandom);
            bus.devHIBYTE  = 1'($urandom);
            bus.devRESET   = ($urandom_range(0, 31) == 0);
            bus.rhCLR      = ($urandom_range(0, 31) == 0);
            bus.rhCLRGO    = ($urandom_range(0, 15) == 0);
            bus.rhCLRTRE   = ($urandom_range(0, 15) == 0);
            bus.rhIACK     = ($urandom_range(0, 3) == 0);
            bus.rhERR      = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            bus.rhUNIT     = 3'($urandom);
            bus.rhBA       = 2'($urandom);
            bus.drvATA     = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            bus.drvERR     = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            bus.drvDVA     = 8'($urandom);
            bus.drvGO      = 8'($urandom);
            bus.drvFUN     = {8'($urandom), 32'($urandom)};
            #1;

            unit = int'(bus.rhUNIT);
            go   = bus.drvGO[unit];
            rdy  = !go;
            ata  = (bus.drvATA != 0);
            sc   = m_tre || ata;
            stat = (bus.rhERR != 0) || bus.drvERR[unit];
            fsh  = bus.drvFUN >> (5 * unit);
            exp_cs1 = int'(sc) * 32768 + int'(m_tre) * 16384 + int'(bus.drvDVA[unit]) * 2048
                    + int'(m_psel) * 1024 + int'(bus.rhBA) * 256 + int'(rdy) * 128
                    + int'(m_ie) * 64 + int'(fsh[4:0]) * 2 + int'(go);

            n_cmp++;
            if (bus.rhCS1 !== 16'(exp_cs1)) begin
                n_bad++; $display("[TB] FAIL rand_cs1 #%0d: got %h want %h", i, bus.rhCS1, 16'(exp_cs1));
            end
            n_cmp++;
            if (bus.rhINTR !== m_pend) begin
                n_bad++; $display("[TB] FAIL rand_intr #%0d: got %b want %b", i, bus.rhINTR, m_pend);
            end

            clr  = bus.devRESET || bus.rhCLR;
            wlo  = bus.rhcs1WRITE && bus.devLOBYTE;
            whi  = bus.rhcs1WRITE && bus.devHIBYTE;
            trig = (m_ie && rdy && !m_lrdy) || (m_ie && sc && !m_lsc)
                || (wlo && d16[6] && !d16[0] && rdy);
            n_pend = clr ? 1'b0 : trig ? 1'b1 : bus.rhIACK ? 1'b0 : m_pend;
            n_ie   = (clr || bus.rhIACK) ? 1'b0 : wlo ? d16[6] : m_ie;
            n_psel = clr ? 1'b0 : (whi && rdy) ? d16[10] : m_psel;
            n_tre  = (clr || bus.rhCLRTRE || bus.rhCLRGO) ? 1'b0 : (stat && !m_ltre) ? 1'b1 : m_tre;
            m_pend = n_pend;
            m_ie   = n_ie;
            m_psel = n_psel;
            m_tre  = n_tre;
            m_ltre = stat;
            m_lrdy = rdy;
            m_lsc  = sc;
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_ie_write();
        test_unit_fun();
        test_tre();
        test_psel();
        test_ata_back_to_back();
        test_unit_switch();
        test_async_rst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rh_cs1_mdrv.md
Name: rh_cs1_mdrv

Overview:
- Parametrised next-generation RH11 Control/Status Register 1 for a Massbus controller serving NDRV drives.
- Builds the 16-bit CS1 image from the currently selected unit's drive signals and from controller error sources.
- Adds an interrupt-request state machine: RDY-edge, SC-edge and IE-write triggers, pending/acknowledge handshake.
- Sits between the UBA device interface and the per-drive register files. Feeds CS1 readback and the controller's interrupt line.

Parameters:
- NDRV, 8, number of drives; power of two, 2..8.
- UW, 3, unit-select width; equals log2(NDRV).
- NERR, 8, number of controller transfer-error sources (RHCS2 DLT/WCE/UPE/NED/NEM/PGE/MXF/DPE).
- IACKCLR, 1, when 1 rhIACK clears IE; when 0 IE is preserved across acknowledge.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- devRESET  in  1  UBA device reset; synchronous clear.
- devLOBYTE  in  1  write low byte.
- devHIBYTE  in  1  write high byte.
- devDATAI  in  36  device data, big-endian [0:35]; CS1 image in bits [15:0] little-endian.
- rhcs1WRITE  in  1  CS1 write strobe, one clk.
- rhCLR  in  1  controller clear (RHCS2[CLR]).
- rhCLRGO  in  1  GO-issue clear of TRE.
- rhCLRTRE  in  1  TRE clear.
- rhERR  in  NERR  controller error levels.
- rhUNIT  in  UW  selected unit (RHCS2[UNIT]).
- rhBA  in  2  bus address bits 17:16.
- rhIACK  in  1  interrupt acknowledge, one clk.
- drvATA  in  NDRV  per-drive attention.
- drvERR  in  NDRV  per-drive composite error.
- drvDVA  in  NDRV  per-drive available.
- drvGO  in  NDRV  per-drive GO.
- drvFUN  in  5*NDRV  per-drive function; drive n occupies bits [5n+4:5n].
- rhCS1  out  16  CS1 readback.
- rhINTR  out  1  interrupt request, level.

Behaviour:
- Selected-unit signals: sGO, sERR, sDVA and sFUN are drv*[rhUNIT]. ATA is the OR of all drvATA bits.
- CS1 layout (15..0): SC, TRE, CPE=0, 0, sDVA, PSEL, rhBA[17:16], RDY, IE, sFUN[5:1], sGO.
- RDY = !sGO.
- SC = TRE | ATA.
- statTRE = |rhERR | sERR. Registered lastTRE, reset 0.
- TRE reset 0.
  - Cleared on devRESET | rhCLR | rhCLRTRE | rhCLRGO; clear beats set in the same cycle.
  - Otherwise set on statTRE & !lastTRE.
- PSEL reset 0.
  - Cleared on devRESET | rhCLR.
  - Loaded from bit 10 on rhcs1WRITE & devHIBYTE & RDY; ignored when RDY=0.
- IE reset 0.
  - Cleared on devRESET | rhCLR, or on rhIACK when IACKCLR=1.
  - Loaded from bit 6 on rhcs1WRITE & devLOBYTE.
  - When a clear source and a write coincide, the clear wins.
- Edge registers lastRDY and lastSC, both reset 0, updated every clk.
- Interrupt state machine: states IDLE and PEND; reset IDLE. rhINTR = (state==PEND).
- IDLE→PEND, registered (rhINTR rises one clk after the trigger cycle), when any of:
  - IE & RDY & !lastRDY;
  - IE & SC & !lastSC;
  - write event: rhcs1WRITE & devLOBYTE & bit6=1 & bit0=0 & RDY. Fires whether or not IE was previously set.
- PEND→IDLE on rhIACK. A trigger in the same cycle as rhIACK re-arms, so the state stays PEND.
- Any state→IDLE on devRESET | rhCLR. rhINTR deasserts the next clk.
- rhUNIT change: edge registers track the new unit's RDY/SC. A unit switch that makes RDY rise with IE=1 does raise an interrupt.
- Async rst mid-PEND: immediate IDLE, rhINTR=0, all registers 0.
- Reset values: rhINTR=0. rhCS1 reflects inputs only, e.g. 16'h0080 with all inputs 0 (RDY=1).

Test Plan:
- Reset, all inputs 0 → rhCS1=16'h0080, rhINTR=0. Pulse rhcs1WRITE, devLOBYTE, data 16'h0040 → IE=1, rhINTR=1 one clk later. rhIACK → rhINTR=0, IE=0.
- rhUNIT=3, drvGO[3]=1, drvFUN[19:15]=5'h19 → rhCS1=16'h0033. drvGO[3]→0 with IE=1 → RDY=1, rhINTR asserts next clk.
- rhERR[4] 0→1 held high → TRE=1, SC=1, rhCS1[15:14]=2'b11. rhCLRTRE pulse → TRE=0 and stays 0 while rhERR[4] is still high. rhERR 0→1 again → TRE=1.
- devHIBYTE write of bit10=1 while drvGO[rhUNIT]=1 → PSEL stays 0. Same write after GO drops → PSEL=1. rhCLR → PSEL=0, IE=0, rhINTR=0.
- IE=1 and drvATA[6] rises → SC edge, rhINTR=1. rhIACK in the same cycle as a new RDY rise → rhINTR stays 1.
- Assert rst asynchronously mid-PEND → rhINTR=0 within the same cycle. TRE, IE and PSEL all read 0.
